mole_round_controller: RTL and testbench
========================================

// Module: mole_round_controller
// PURPOSE
//  Game sequencer for the whack-a-mole datapath. Runs the round FSM
//  (idle / play / game over), schedules mole spawns and per-mole lifetimes,
//  and owns score, misses, difficulty level and the countdown timer.
//  Sits between the random position generator and keypad hit detector
//  (inputs) and the dot-matrix and 7-segment display blocks (outputs).
// PARAMETERS
//  GAME_TIME       60   round length in tick_sec pulses (max 63)
//  MOLE_LIFE_INIT  40   initial mole lifetime in tick_fast pulses (max 255)
//  MOLE_LIFE_MIN   10   lifetime floor
//  LIFE_STEP       4    lifetime reduction per level-up
//  HITS_PER_LEVEL  5    hits needed for one level-up
//  GAP_TICKS       8    blank tick_fast pulses between a mole ending and the next spawn (>=1)
//  MAX_SCORE       999  score saturation value
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  start        in   1   raw start button, active-low, asynchronous
//  tick_sec     in   1   1-clk pulse, once per second
//  tick_fast    in   1   1-clk pulse, lifetime base (~10 ms)
//  hit_in       in   1   level from keypad: 1 = mole key pressed
//  rand_row     in   2   random row candidate
//  rand_col     in   2   random column candidate
//  is_started   out  1   1 in ARM/SPAWN/ACTIVE/GAP
//  game_over    out  1   1 in OVER
//  mole_valid   out  1   mole visible and hittable
//  mole_row     out  2   current mole row
//  mole_col     out  2   current mole column
//  score        out  10  hits, saturating at MAX_SCORE
//  miss_count   out  8   expired moles, saturating at 255
//  level        out  3   difficulty level, saturating at 7
//  time_left    out  6   remaining seconds
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except time_left=GAME_TIME.
//  start is 2-flop synchronised; a falling edge of the synchronised value
//   is the start event. hit_in is registered; a rising edge is the hit event.
//  IDLE: hit and tick events are ignored. A start event moves to ARM.
//  ARM (1 clk): load time_left=GAME_TIME, score=0, miss_count=0, level=0,
//   life=MOLE_LIFE_INIT, hit counter=0; go to SPAWN.
//  SPAWN (1 clk): latch rand_row/rand_col.
//   If the candidate equals the previous position, col=(rand_col+1) mod 4.
//   Set life_cnt=life, mole_valid=1; go to ACTIVE.
//  ACTIVE: a hit event increments score (saturating) in the next clk,
//   clears mole_valid and increments the hit counter.
//   When the hit counter reaches HITS_PER_LEVEL: clear it, level+1 (sat),
//   life=max(life-LIFE_STEP, MOLE_LIFE_MIN); this takes effect from the next SPAWN.
//   Then go to GAP.
//   Each tick_fast decrements life_cnt. When life_cnt reaches 0:
//   miss_count+1 (sat), mole_valid=0; go to GAP.
//   A hit and an expiry in the same clk: the hit wins; no miss is counted.
//  GAP: count GAP_TICKS tick_fast pulses with mole_valid=0, then go to SPAWN.
//  Timer: in ARM..GAP each tick_sec decrements time_left. On the transition
//   1->0, go to OVER next clk and clear mole_valid. A hit in that same clk still scores.
//  OVER: game_over=1; score, miss_count and level are held;
//   mole_row/col hold their last value. A start event moves to ARM.
//   A start event during play is ignored.
//  Reset asserted mid-round: immediate return to reset values.
// CONFIGURATION
//  MISS_PENALTY_EN defined: each expiry also decrements score by 1,
//   saturating at 0, in the same clk as the miss_count increment.
//  MISS_PENALTY_EN undefined: an expiry only increments miss_count; score is untouched.
// TESTING
//  1 Reset, start low 4 clk -> is_started=1 within 4 clk,
//    time_left=60, score=0, mole_valid=1 two clk after ARM.
//  2 Press hit_in for 100 clk during ACTIVE -> score +1 exactly once,
//    mole_valid=0, respawn after 8 tick_fast pulses.
//  3 No hit, 40 tick_fast pulses -> miss_count=1, mole_valid drops;
//    score is unchanged (MISS_PENALTY_EN off) or sat-decrements (on).
//  4 5 hits -> level=1 and the next mole expires after 36 tick_fast pulses;
//    after 8 level-ups the lifetime floors at 10 and level stays 7.
//  5 60 tick_sec pulses -> time_left=0, game_over=1, mole_valid=0;
//    a hit in the final clk counts; later hits are ignored; start restarts with score=0.
//  6 Force rand equal to the previous position -> new col = old col+1 mod 4;
//    hit and expiry in the same clk -> score+1, miss unchanged.

Source files
------------

// File: rtl/mole_round_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mole_round_controller                                      |
// | Description : Round sequencer for the whack-a-mole game. Runs the        |
// |               idle / play / game-over FSM, schedules mole spawns and     |
// |               lifetimes, and owns score, misses, level and countdown.    |
// | Ports       : clk, reset (async, active-low), start (raw, active-low),   |
// |               tick_sec / tick_fast (1-clk pulses), hit_in (keypad level),|
// |               rand_row / rand_col (position candidate);                  |
// |               is_started, game_over, mole_valid, mole_row, mole_col,     |
// |               score, miss_count, level, time_left.                       |
// | Options     : MISS_PENALTY_EN - an expiry also takes one point off score.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mole_round_controller #(
    parameter int GAME_TIME      = 60,
    parameter int MOLE_LIFE_INIT = 40,
    parameter int MOLE_LIFE_MIN  = 10,
    parameter int LIFE_STEP      = 4,
    parameter int HITS_PER_LEVEL = 5,
    parameter int GAP_TICKS      = 8,
    parameter int MAX_SCORE      = 999
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tick_sec,
    input  logic       tick_fast,
    input  logic       hit_in,
    input  logic [1:0] rand_row,
    input  logic [1:0] rand_col,
    output logic       is_started,
    output logic       game_over,
    output logic       mole_valid,
    output logic [1:0] mole_row,
    output logic [1:0] mole_col,
    output logic [9:0] score,
    output logic [7:0] miss_count,
    output logic [2:0] level,
    output logic [5:0] time_left
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_ARM    = 3'd1;
    localparam logic [2:0] c_ST_SPAWN  = 3'd2;
    localparam logic [2:0] c_ST_ACTIVE = 3'd3;
    localparam logic [2:0] c_ST_GAP    = 3'd4;
    localparam logic [2:0] c_ST_OVER   = 3'd5;

    localparam logic [5:0] c_GAME_TIME = 6'(GAME_TIME);
    localparam logic [7:0] c_LIFE_INIT = 8'(MOLE_LIFE_INIT);
    localparam logic [7:0] c_LIFE_MIN  = 8'(MOLE_LIFE_MIN);
    localparam logic [7:0] c_LIFE_STEP = 8'(LIFE_STEP);
    localparam logic [8:0] c_LIFE_KNEE = 9'(MOLE_LIFE_MIN + LIFE_STEP);
    localparam logic [7:0] c_HIT_LAST  = 8'(HITS_PER_LEVEL - 1);
    localparam logic [7:0] c_GAP_LAST  = 8'(GAP_TICKS - 1);
    localparam logic [9:0] c_MAX_SCORE = 10'(MAX_SCORE);

    logic [2:0] r_state;
    logic [2:0] w_state_next;

    logic       r_start_s1, r_start_s2, r_start_d;
    logic       r_hit_q, r_hit_d;
    logic [5:0] r_time_left;
    logic [9:0] r_score;
    logic [7:0] r_miss;
    logic [2:0] r_level;
    logic [7:0] r_life;
    logic [7:0] r_life_cnt;
    logic [7:0] r_hit_cnt;
    logic [7:0] r_gap_cnt;
    logic       r_mole_valid;
    logic [1:0] r_mole_row, r_mole_col;

    logic       w_start_evt, w_hit_evt, w_play;
    logic       w_hit_now, w_expire, w_level_up, w_gap_done, w_time_up;
    logic [1:0] w_spawn_col;
    logic [7:0] w_life_dec;
    logic [9:0] w_score_inc;

    // start is active-low: a falling edge of the synchronised level starts a round.
    assign w_start_evt = r_start_d & ~r_start_s2;
    assign w_hit_evt   = r_hit_q & ~r_hit_d;
    assign w_play      = (r_state == c_ST_SPAWN) || (r_state == c_ST_ACTIVE) ||
                         (r_state == c_ST_GAP);
    assign w_hit_now   = (r_state == c_ST_ACTIVE) && w_hit_evt;
    // A hit in the same clock as the last lifetime tick takes priority.
    assign w_expire    = (r_state == c_ST_ACTIVE) && !w_hit_evt && tick_fast &&
                         (r_life_cnt <= 8'd1);
    assign w_level_up  = (r_hit_cnt >= c_HIT_LAST);
    assign w_gap_done  = (r_state == c_ST_GAP) && tick_fast && (r_gap_cnt >= c_GAP_LAST);
    assign w_time_up   = w_play && tick_sec && (r_time_left == 6'd1);

    // Never respawn on the same cell twice in a row.
    assign w_spawn_col = ((rand_row == r_mole_row) && (rand_col == r_mole_col)) ?
                         rand_col + 2'd1 : rand_col;
    assign w_life_dec  = ({1'b0, r_life} >= c_LIFE_KNEE) ? r_life - c_LIFE_STEP : c_LIFE_MIN;
    assign w_score_inc = (r_score >= c_MAX_SCORE) ? r_score : r_score + 10'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_start_evt) w_state_next = c_ST_ARM;
            c_ST_ARM:    w_state_next = c_ST_SPAWN;
            c_ST_SPAWN:  w_state_next = c_ST_ACTIVE;
            c_ST_ACTIVE: if (w_hit_now || w_expire) w_state_next = c_ST_GAP;
            c_ST_GAP:    if (w_gap_done) w_state_next = c_ST_SPAWN;
            c_ST_OVER:   if (w_start_evt) w_state_next = c_ST_ARM;
            default:     w_state_next = c_ST_IDLE;
        endcase
        // Running out of time overrides any play transition.
        if (w_time_up) w_state_next = c_ST_OVER;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start_s1   <= 1'b1;
            r_start_s2   <= 1'b1;
            r_start_d    <= 1'b1;
            r_hit_q      <= 1'b0;
            r_hit_d      <= 1'b0;
            r_time_left  <= c_GAME_TIME;
            r_score      <= '0;
            r_miss       <= '0;
            r_level      <= '0;
            r_life       <= c_LIFE_INIT;
            r_life_cnt   <= '0;
            r_hit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_mole_valid <= 1'b0;
            r_mole_row   <= '0;
            r_mole_col   <= '0;
        end else begin
            r_start_s1 <= start;
            r_start_s2 <= r_start_s1;
            r_start_d  <= r_start_s2;
            r_hit_q    <= hit_in;
            r_hit_d    <= r_hit_q;

            case (r_state)
                c_ST_ARM: begin
                    r_time_left <= c_GAME_TIME;
                    r_score     <= '0;
                    r_miss      <= '0;
                    r_level     <= '0;
                    r_life      <= c_LIFE_INIT;
                    r_hit_cnt   <= '0;
                end
                c_ST_SPAWN: begin
                    r_mole_row   <= rand_row;
                    r_mole_col   <= w_spawn_col;
                    r_life_cnt   <= r_life;
                    r_mole_valid <= 1'b1;
                end
                c_ST_ACTIVE: begin
                    if (w_hit_evt) begin
                        r_score      <= w_score_inc;
                        r_mole_valid <= 1'b0;
                        r_gap_cnt    <= '0;
                        if (w_level_up) begin
                            r_hit_cnt <= '0;
                            r_life    <= w_life_dec;
                            if (r_level != 3'd7) r_level <= r_level + 3'd1;
                        end else begin
                            r_hit_cnt <= r_hit_cnt + 8'd1;
                        end
                    end else if (tick_fast) begin
                        if (w_expire) begin
                            r_mole_valid <= 1'b0;
                            r_gap_cnt    <= '0;
                            if (r_miss != 8'hFF) r_miss <= r_miss + 8'd1;
`ifdef MISS_PENALTY_EN
                            if (r_score != 10'd0) r_score <= r_score - 10'd1;
`endif
                        end else begin
                            r_life_cnt <= r_life_cnt - 8'd1;
                        end
                    end
                end
                c_ST_GAP: begin
                    if (tick_fast) r_gap_cnt <= r_gap_cnt + 8'd1;
                end
                default: ;
            endcase

            if (w_play && tick_sec && (r_time_left != 6'd0)) begin
                r_time_left <= r_time_left - 6'd1;
            end
            if (w_time_up) r_mole_valid <= 1'b0;
        end
    end

    assign is_started = (r_state == c_ST_ARM) || w_play;
    assign game_over  = (r_state == c_ST_OVER);
    assign mole_valid = r_mole_valid;
    assign mole_row   = r_mole_row;
    assign mole_col   = r_mole_col;
    assign score      = r_score;
    assign miss_count = r_miss;
    assign level      = r_level;
    assign time_left  = r_time_left;

endmodule
`default_nettype wire

// File: tb/tb_mole_round_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mole_round_controller                                   |
// | Description : Self-checking bench for mole_round_controller. Stimulus    |
// |               queues the expected state for every mole appear/vanish,    |
// |               round start and game-over event; a monitor pops and        |
// |               compares when the DUT shows that event.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mole_round_controller;

    localparam int C_GAP   = 8;
    localparam int K_START = 0;
    localparam int K_RISE  = 1;
    localparam int K_FALL  = 2;
    localparam int K_OVER  = 3;

    logic       clk = 1'b0;
    logic       reset, start, tick_sec, tick_fast, hit_in;
    logic [1:0] rand_row, rand_col;
    logic       is_started, game_over, mole_valid;
    logic [1:0] mole_row, mole_col;
    logic [9:0] score;
    logic [7:0] miss_count;
    logic [2:0] level;
    logic [5:0] time_left;

    mole_round_controller dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .tick_sec   (tick_sec),
        .tick_fast  (tick_fast),
        .hit_in     (hit_in),
        .rand_row   (rand_row),
        .rand_col   (rand_col),
        .is_started (is_started),
        .game_over  (game_over),
        .mole_valid (mole_valid),
        .mole_row   (mole_row),
        .mole_col   (mole_col),
        .score      (score),
        .miss_count (miss_count),
        .level      (level),
        .time_left  (time_left)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int kind;
        int score;
        int miss;
        int level;
        int row;
        int col;
        int tleft;
        int fcnt;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_ev     = 0;
    int  fcnt     = 0;
    int  g_sp     = 3;

    // Lifetime after 0..8 level-ups: 40 - 4*n, floored at 10.
    int c_life [0:8] = '{40, 36, 32, 28, 24, 20, 16, 12, 10};

    int m_score = 0, m_miss = 0, m_level = 0, m_hits = 0, m_lvlups = 0;
    int m_row = 0, m_col = 0, m_tleft = 60;

    function automatic int cur_life();
        return c_life[(m_lvlups > 8) ? 8 : m_lvlups];
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic check_event(input int kind);
        ev_t a, e;
        a.kind  = kind;           a.score = int'(score);  a.miss  = int'(miss_count);
        a.level = int'(level);    a.row   = int'(mole_row); a.col = int'(mole_col);
        a.tleft = int'(time_left); a.fcnt = fcnt;
        n_checks++;
        n_ev++;
        if (exp_q.size() == 0) begin
            $display("FAIL event_%0d unexpected: got kind=%0d score=%0d miss=%0d level=%0d, required no event",
                     n_ev, a.kind, a.score, a.miss, a.level);
        end else begin
            e = exp_q.pop_front();
            if (a == e) n_pass++;
            else $display("FAIL event_%0d: got kind=%0d score=%0d miss=%0d level=%0d row=%0d col=%0d time=%0d fast=%0d, required kind=%0d score=%0d miss=%0d level=%0d row=%0d col=%0d time=%0d fast=%0d",
                          n_ev, a.kind, a.score, a.miss, a.level, a.row, a.col, a.tleft, a.fcnt,
                          e.kind, e.score, e.miss, e.level, e.row, e.col, e.tleft, e.fcnt);
        end
    endtask

    // Monitor: compares on every visible DUT event.
    initial begin : monitor
        logic p_started, p_valid, p_over;
        p_started = 1'b0; p_valid = 1'b0; p_over = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                p_started = 1'b0; p_valid = 1'b0; p_over = 1'b0;
            end else begin
                if (is_started && !p_started) check_event(K_START);
                if (mole_valid && !p_valid)   check_event(K_RISE);
                if (!mole_valid && p_valid)   check_event(K_FALL);
                if (game_over && !p_over)     check_event(K_OVER);
                p_started = is_started; p_valid = mole_valid; p_over = game_over;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1, "timeout");
    end

    task automatic push(input int kind, input int f);
        ev_t e;
        e.kind = kind;  e.score = m_score; e.miss = m_miss; e.level = m_level;
        e.row = m_row;  e.col = m_col;     e.tleft = m_tleft; e.fcnt = f;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_fast(input int n);
        for (int i = 0; i < n; i++) begin
            step(1); tick_fast = 1'b1; fcnt++;
            step(1); tick_fast = 1'b0;
        end
    endtask

    task automatic pulse_sec(input int n);
        for (int i = 0; i < n; i++) begin
            step(1); tick_sec = 1'b1; m_tleft--;
            step(1); tick_sec = 1'b0;
        end
    endtask

    task automatic model_hit();
        if (m_score < 999) m_score++;
        m_hits++;
        if (m_hits == 5) begin
            m_hits = 0;
            m_lvlups++;
            m_level = (m_lvlups > 7) ? 7 : m_lvlups;
        end
    endtask

    task automatic model_miss();
        if (m_miss < 255) m_miss++;
`ifdef MISS_PENALTY_EN
        if (m_score > 0) m_score--;
`endif
    endtask

    task automatic spawn_next(input int r, input int c, input int exp_col);
        rand_row = 2'(r);
        rand_col = 2'(c);
        m_row = r;
        m_col = exp_col;
        push(K_RISE, fcnt + C_GAP);
        pulse_fast(C_GAP);
        step(3);
    endtask

    task automatic spawn_auto();
        spawn_next(g_sp % 4, (g_sp + 1) % 4, (g_sp + 1) % 4);
        g_sp++;
    endtask

    task automatic do_hit();
        model_hit();
        push(K_FALL, fcnt);
        step(1); hit_in = 1'b1;
        step(2); hit_in = 1'b0;
        step(3);
    endtask

    task automatic do_expire();
        int life;
        life = cur_life();
        model_miss();
        push(K_FALL, fcnt + life);
        pulse_fast(life);
        step(3);
    endtask

    // Hit event and last lifetime tick land in the same clock.
    task automatic do_hit_expire();
        int life;
        life = cur_life();
        pulse_fast(life - 1);
        model_hit();
        push(K_FALL, fcnt + 1);
        step(1); hit_in = 1'b1;
        step(1); tick_fast = 1'b1; fcnt++;
        step(1); tick_fast = 1'b0;
        step(1); hit_in = 1'b0;
        step(3);
    endtask

    task automatic start_round(input int r, input int c, input int exp_col);
        push(K_START, fcnt);
        m_score = 0; m_miss = 0; m_level = 0; m_hits = 0; m_lvlups = 0; m_tleft = 60;
        m_row = r; m_col = exp_col;
        rand_row = 2'(r);
        rand_col = 2'(c);
        push(K_RISE, fcnt);
        step(1); start = 1'b0;
        step(4); start = 1'b1;
        check("started_after_4clk", int'(is_started), 1);
        step(3);
    endtask

    initial begin : stimulus
        reset = 1'b0; start = 1'b1; tick_sec = 1'b0; tick_fast = 1'b0; hit_in = 1'b0;
        rand_row = 2'd0; rand_col = 2'd0;
        step(3);
        reset = 1'b1;
        step(1);
        check("reset_is_started", int'(is_started), 0);
        check("reset_game_over",  int'(game_over),  0);
        check("reset_mole_valid", int'(mole_valid), 0);
        check("reset_score",      int'(score),      0);
        check("reset_miss",       int'(miss_count), 0);
        check("reset_level",      int'(level),      0);
        check("reset_time_left",  int'(time_left),  60);

        // Hits and ticks in IDLE do nothing.
        step(1); hit_in = 1'b1; step(3); hit_in = 1'b0;
        pulse_fast(3); pulse_sec(1); m_tleft = 60;
        check("idle_score", int'(score), 0);
        check("idle_time",  int'(time_left), 60);

        // Start the round: STARTED shows the reset values, first mole at (1,2).
        start_round(1, 2, 2);

        // Held hit scores once.
        model_hit();
        push(K_FALL, fcnt);
        step(1); hit_in = 1'b1;
        step(100); hit_in = 1'b0;
        step(2);
        check("held_hit_score", int'(score), 1);

        // Same cell proposed again: column moves to 3.
        spawn_next(1, 2, 3);
        do_expire();
        spawn_next(2, 0, 0);

        // Reach the first level-up, then a 36-tick mole.
        repeat (4) begin
            do_hit();
            spawn_auto();
        end
        check("level_after_5_hits", int'(level), 1);
        do_expire();

        // Drive to 8 level-ups: level stays 7, life floors at 10.
        spawn_auto();
        repeat (35) begin
            do_hit();
            spawn_auto();
        end
        check("level_saturated", int'(level), 7);
        do_expire();

        // Hit and expiry together, then column wrap 3 -> 0.
        spawn_next(0, 3, 3);
        do_hit_expire();
        spawn_next(0, 3, 0);

        // Countdown to zero with a hit in the final clock.
        pulse_sec(59);
        check("time_left_one", int'(time_left), 1);
        model_hit();
        m_tleft = 0;
        push(K_FALL, fcnt);
        push(K_OVER, fcnt);
        step(1); hit_in = 1'b1;
        step(1); tick_sec = 1'b1;
        step(1); tick_sec = 1'b0;
        step(1); hit_in = 1'b0;
        step(3);

        // Game over holds everything; hits and ticks are ignored.
        step(1); hit_in = 1'b1; step(3); hit_in = 1'b0;
        pulse_fast(12);
        step(1); tick_sec = 1'b1; step(1); tick_sec = 1'b0;
        step(2);
        check("over_score_held", int'(score), m_score);
        check("over_miss_held",  int'(miss_count), m_miss);
        check("over_game_over",  int'(game_over), 1);
        check("over_mole_valid", int'(mole_valid), 0);
        check("over_time_left",  int'(time_left), 0);

        // Restart clears score and reloads the 40-tick lifetime.
        start_round(2, 2, 2);
        do_hit();
        spawn_auto();
        do_expire();
        spawn_auto();

        // Reset in the middle of play.
        reset = 1'b0;
        #2;
        check("midreset_is_started", int'(is_started), 0);
        check("midreset_mole_valid", int'(mole_valid), 0);
        check("midreset_score",      int'(score), 0);
        check("midreset_miss",       int'(miss_count), 0);
        check("midreset_time_left",  int'(time_left), 60);
        step(2);
        reset = 1'b1;
        step(5);
        check("pending_events", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
